// File: rtl/tick_rr_scheduler.sv
// Divide-by-N tick generator with a round-robin grant of each tick among N_REQ requesters.
// Optional macro DIV_SYNC_RESTART_EN: apply an accepted divisor at once instead of at the period boundary.
module tick_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DIV_W   = 4,
  parameter int DIV_RST = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  input  logic [DIV_W-1:0]         cfg_div,
  output logic                     cfg_ready,
  input  logic [N_REQ-1:0]         req,
  output logic                     tick,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic [DIV_W-1:0]         cur_div
);

  localparam int ID_W = $clog2(N_REQ);

  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic             pend_reg, pend_next;
  logic [ID_W-1:0]  ptr_reg, ptr_next;
  logic [ID_W-1:0]  sel_id;
  logic             sel_found;
  logic             wrap;
  logic             accept;
  logic [DIV_W-1:0] cfg_div_norm;

  assign tick         = (cnt_reg == '0);
  assign wrap         = (cnt_reg == div_reg - DIV_W'(1));
  assign cfg_div_norm = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign cfg_ready    = reset & ~pend_reg;
  assign accept       = cfg_valid & cfg_ready;
  assign cur_div      = div_reg;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg  <= '0;
      div_reg  <= DIV_W'(DIV_RST);
      pend_reg <= 1'b0;
      ptr_reg  <= '0;
    end else begin
      cnt_reg  <= cnt_next;
      div_reg  <= div_next;
      pend_reg <= pend_next;
      ptr_reg  <= ptr_next;
    end
  end

`ifdef DIV_SYNC_RESTART_EN
  // Immediate restart: a new divisor starts a fresh period on the accept edge.
  always_comb begin
    cnt_next  = wrap ? '0 : cnt_reg + DIV_W'(1);
    div_next  = div_reg;
    pend_next = 1'b0;
    if (accept) begin
      div_next = cfg_div_norm;
      cnt_next = '0;
    end
  end
`else
  logic [DIV_W-1:0] pend_div_reg, pend_div_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_div_reg <= DIV_W'(DIV_RST);
    end else begin
      pend_div_reg <= pend_div_next;
    end
  end

  // Accept and apply never coincide: accept needs pend=0, apply needs pend=1.
  always_comb begin
    cnt_next      = wrap ? '0 : cnt_reg + DIV_W'(1);
    div_next      = div_reg;
    pend_next     = pend_reg;
    pend_div_next = pend_div_reg;
    if (wrap && pend_reg) begin
      div_next  = pend_div_reg;
      pend_next = 1'b0;
    end
    if (accept) begin
      pend_next     = 1'b1;
      pend_div_next = cfg_div_norm;
    end
  end
`endif

  // Search requesters starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [ID_W:0] sum;
    sel_found = 1'b0;
    sel_id    = '0;
    sum       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_reg} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      if (!sel_found && req[ID_W'(sum)]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(sum);
      end
    end
  end

  assign gnt_valid = reset & tick & sel_found;
  assign gnt_id    = gnt_valid ? sel_id : '0;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign gnt[gi] = gnt_valid && (gnt_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    ptr_next = ptr_reg;
    if (gnt_valid) begin
      ptr_next = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule
